pwm_seq_ctrl: RTL and testbench
===============================

Name: pwm_seq_ctrl

Overview:
Run-time controller for the complementary PWM/deadtime datapath driving pwm_out1/pwm_out2. It accepts duty/deadtime configuration through a valid/ready handshake, holds it in a single-entry shadow register and commits it only at PWM period boundaries. It sequences enable, soft-start ramp and fault shutdown, and drives the duty, deadtime and enable inputs of the PWM core.

Parameters:
CNT_W, 10, width of PWM counter and duty values
DT_W, 6, deadtime width in clk cycles
STEP, 4, soft-start duty increment per PWM period
DUTY_MAX, 1000, upper clamp for duty
DT_MIN, 8, lower clamp for deadtime

Ports:
clk  in  1  system clock (200 MHz)
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  config request valid
cfg_ready  out  1  shadow register free
cfg_duty  in  CNT_W  requested duty
cfg_deadtime  in  DT_W  requested deadtime
start  in  1  level enable request
fault  in  1  external fault, level
fault_clr  in  1  fault-clear pulse
period_end  in  1  one-cycle strobe from PWM core at counter wrap
duty_cmd  out  CNT_W  duty applied to PWM core
deadtime_cmd  out  DT_W  deadtime applied to PWM core
pwm_en  out  1  PWM core output enable
state  out  2  IDLE=0, RAMP=1, RUN=2, FAULT=3
fault_latched  out  1  sticky fault flag

Behaviour:
- Reset (rst=0, async): duty_cmd=0, deadtime_cmd=DT_MIN, pwm_en=0, cfg_ready=1, state=IDLE, fault_latched=0, target=0, pending=0.
- All outputs registered. State changes take effect 1 cycle after the causing input.
- Handshake: accept when cfg_valid&cfg_ready. Clamp on accept: duty=min(cfg_duty,DUTY_MAX), deadtime=max(cfg_deadtime,DT_MIN). Set pending=1. cfg_ready=!pending.
- Commit (pending→target/deadtime_cmd, pending=0): in IDLE/FAULT, on the cycle after acceptance; in RAMP/RUN, only on period_end. An accept coinciding with a period_end commits at the following period_end.
- IDLE: pwm_en=0, duty_cmd=0. start=1 & !fault_latched → RAMP; pwm_en=1, duty_cmd=0.
- RAMP: on period_end, duty_cmd=min(duty_cmd+STEP, target), computed in CNT_W+1 bits (no wrap). If the result equals target → RUN. target=0 → RUN at the first period_end.
- RUN: duty_cmd follows the committed target at period_end with no ramping.
- start=0 in RAMP/RUN → IDLE next cycle; pwm_en=0, duty_cmd=0. The pending config is kept.
- fault=1 in any state (highest priority) → FAULT next cycle; pwm_en=0, duty_cmd=0, fault_latched=1.
- FAULT exits to IDLE only when fault_clr=1 & fault=0 & start=0. That cycle clears fault_latched. fault_clr is ignored otherwise.
- period_end is ignored in IDLE/FAULT.

Optional Feature:
PWM_SOFTSTART_EN. Defined: RAMP state as above. Undefined: RAMP is unreachable; IDLE→RUN directly with duty_cmd=target on entry. STEP is unused.

Decomposition:
- Package pwm_ctrl_pkg: state encoding constants (IDLE/RAMP/RUN/FAULT), default CNT_W/DT_W/DT_MIN/DUTY_MAX.
- Sub-module pwm_ramp_step: saturating duty+STEP toward target, with a done flag; combinational, instantiated once.
- FSM and shadow register stay in pwm_seq_ctrl.

Test Plan:
- Reset: drive rst=0 mid-activity → same cycle duty_cmd=0, deadtime_cmd=8, pwm_en=0, state=0, cfg_ready=1.
- Soft-start: cfg duty=10, dt=20 in IDLE, then start=1; pulse period_end 3 times → deadtime_cmd=20, duty_cmd 4→8→10, state=RUN after the third pulse.
- Clamping: cfg duty=1023, dt=3 → committed target=1000, deadtime_cmd=8.
- Boundary commit: in RUN with duty=10, accept duty=500 on the same cycle as period_end → duty stays 10, cfg_ready=0; next period_end → duty_cmd=500, cfg_ready=1.
- Fault: fault=1 during RAMP → next cycle pwm_en=0, duty_cmd=0, state=3, fault_latched=1. fault_clr with fault=1 is ignored. fault=0, start=0, fault_clr=1 → IDLE.
- Without PWM_SOFTSTART_EN: target=300, start=1 → next cycle state=RUN, duty_cmd=300, pwm_en=1.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
//   Shared definitions for the PWM sequencing controller: the state
//   encoding that appears on the state output, and the default parameter
//   values used by pwm_seq_ctrl and pwm_ramp_step.
package pwm_ctrl_pkg;

    localparam int CNT_W_DEF    = 10;
    localparam int DT_W_DEF     = 6;
    localparam int STEP_DEF     = 4;
    localparam int DUTY_MAX_DEF = 1000;
    localparam int DT_MIN_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_ramp_step.sv
// pwm_ramp_step
//   Combinational soft-start step: advances duty by STEP toward target and
//   saturates at target. The sum is formed one bit wider than CNT_W, so a
//   duty near full scale cannot wrap.
// Ports:
//   duty      in   CNT_W  duty currently applied
//   target    in   CNT_W  duty the ramp is heading for
//   duty_next out  CNT_W  min(duty + STEP, target)
//   done      out  1      duty_next has reached target
module pwm_ramp_step #(
    parameter int CNT_W = 10,
    parameter int STEP  = 4
) (
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] duty_next,
    output logic             done
);

    logic [CNT_W:0] sum;

    assign sum = {1'b0, duty} + (CNT_W+1)'(STEP);

    always_comb begin
        duty_next = sum[CNT_W-1:0];
        done      = 1'b0;
        if (sum >= {1'b0, target}) begin
            duty_next = target;
            done      = 1'b1;
        end
    end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl
//   Run-time sequencer for the complementary PWM/deadtime core. It takes
//   duty/deadtime through a valid/ready handshake into a single-entry
//   shadow register. The shadow is committed at once in IDLE/FAULT, and
//   only on period_end in RAMP/RUN. It also sequences enable, soft-start
//   and a sticky fault shutdown.
//   Optional macro PWM_SOFTSTART_EN: when defined, IDLE goes through RAMP.
//   When undefined, IDLE jumps straight to RUN at full target duty, and the
//   STEP parameter does not exist.
// Ports:
//   clk           in   1      system clock
//   rst           in   1      asynchronous reset, active low
//   cfg_valid     in   1      config request valid
//   cfg_ready     out  1      shadow register free
//   cfg_duty      in   CNT_W  requested duty (clamped to DUTY_MAX)
//   cfg_deadtime  in   DT_W   requested deadtime (clamped to DT_MIN)
//   start         in   1      level enable request
//   fault         in   1      external fault level, highest priority
//   fault_clr     in   1      fault-clear pulse
//   period_end    in   1      counter-wrap strobe from the PWM core
//   duty_cmd      out  CNT_W  duty applied to the PWM core
//   deadtime_cmd  out  DT_W   deadtime applied to the PWM core
//   pwm_en        out  1      PWM core output enable
//   state         out  2      IDLE=0 RAMP=1 RUN=2 FAULT=3
//   fault_latched out  1      sticky fault flag
//
// state | meaning
// IDLE  | outputs off, waiting for start
// RAMP  | duty stepped toward target once per period
// RUN   | duty tracks committed target at period boundaries
// FAULT | outputs off until fault_clr with fault and start low
module pwm_seq_ctrl
    import pwm_ctrl_pkg::*;
#(
`ifdef PWM_SOFTSTART_EN
    parameter int STEP     = STEP_DEF,
`endif
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DT_W     = DT_W_DEF,
    parameter int DUTY_MAX = DUTY_MAX_DEF,
    parameter int DT_MIN   = DT_MIN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic [DT_W-1:0]  cfg_deadtime,
    input  logic             start,
    input  logic             fault,
    input  logic             fault_clr,
    input  logic             period_end,
    output logic [CNT_W-1:0] duty_cmd,
    output logic [DT_W-1:0]  deadtime_cmd,
    output logic             pwm_en,
    output logic [1:0]       state,
    output logic             fault_latched
);

    localparam logic [CNT_W-1:0] DUTY_MAX_V = CNT_W'(DUTY_MAX);
    localparam logic [DT_W-1:0]  DT_MIN_V   = DT_W'(DT_MIN);

    pwm_state_t       state_q, state_n;
    logic [CNT_W-1:0] duty_n, target_q, target_n, pend_duty_q, pend_duty_n;
    logic [DT_W-1:0]  dt_n, pend_dt_q, pend_dt_n;
    logic             pending_q, pending_n, en_n, latched_n;
    logic             accept, commit, in_run;
    logic [CNT_W-1:0] eff_target;

    assign cfg_ready = ~pending_q;
    assign state     = state_q;
    assign accept    = cfg_valid & ~pending_q;
    assign in_run    = (state_q == ST_RAMP) || (state_q == ST_RUN);
    assign commit    = pending_q & (in_run ? period_end : 1'b1);
    // Duty updates on a committing period_end use the new target immediately.
    assign eff_target = commit ? pend_duty_q : target_q;

`ifdef PWM_SOFTSTART_EN
    logic [CNT_W-1:0] ramp_next;
    logic             ramp_done;

    pwm_ramp_step #(
        .CNT_W (CNT_W),
        .STEP  (STEP)
    ) u_ramp (
        .duty      (duty_cmd),
        .target    (eff_target),
        .duty_next (ramp_next),
        .done      (ramp_done)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            duty_cmd      <= '0;
            deadtime_cmd  <= DT_MIN_V;
            pwm_en        <= 1'b0;
            fault_latched <= 1'b0;
            target_q      <= '0;
            pend_duty_q   <= '0;
            pend_dt_q     <= DT_MIN_V;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_n;
            duty_cmd      <= duty_n;
            deadtime_cmd  <= dt_n;
            pwm_en        <= en_n;
            fault_latched <= latched_n;
            target_q      <= target_n;
            pend_duty_q   <= pend_duty_n;
            pend_dt_q     <= pend_dt_n;
            pending_q     <= pending_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        duty_n      = duty_cmd;
        dt_n        = deadtime_cmd;
        en_n        = pwm_en;
        latched_n   = fault_latched;
        target_n    = target_q;
        pend_duty_n = pend_duty_q;
        pend_dt_n   = pend_dt_q;
        pending_n   = pending_q;

        // Accept needs an empty shadow and commit needs a full one, so they never overlap.
        if (accept) begin
            pending_n   = 1'b1;
            pend_duty_n = (cfg_duty > DUTY_MAX_V) ? DUTY_MAX_V : cfg_duty;
            pend_dt_n   = (cfg_deadtime < DT_MIN_V) ? DT_MIN_V : cfg_deadtime;
        end
        if (commit) begin
            pending_n = 1'b0;
            target_n  = pend_duty_q;
            dt_n      = pend_dt_q;
        end

        case (state_q)
            ST_IDLE: begin
                en_n   = 1'b0;
                duty_n = '0;
                if (start && !fault_latched) begin
                    en_n = 1'b1;
`ifdef PWM_SOFTSTART_EN
                    state_n = ST_RAMP;
`else
                    state_n = ST_RUN;
                    duty_n  = eff_target;
`endif
                end
            end
`ifdef PWM_SOFTSTART_EN
            ST_RAMP: begin
                if (!start) begin
                    state_n = ST_IDLE;
                    en_n    = 1'b0;
                    duty_n  = '0;
                end else if (period_end) begin
                    duty_n = ramp_next;
                    if (ramp_done) state_n = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                if (!start) begin
                    state_n = ST_IDLE;
                    en_n    = 1'b0;
                    duty_n  = '0;
                end else if (period_end) begin
                    duty_n = eff_target;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !fault && !start) begin
                    state_n   = ST_IDLE;
                    latched_n = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                en_n    = 1'b0;
                duty_n  = '0;
            end
        endcase

        if (fault) begin
            state_n   = ST_FAULT;
            en_n      = 1'b0;
            duty_n    = '0;
            latched_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
module tb_pwm_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid, cfg_ready;
    logic [9:0] cfg_duty;
    logic [5:0] cfg_deadtime;
    logic       start, fault, fault_clr, period_end;
    logic [9:0] duty_cmd;
    logic [5:0] deadtime_cmd;
    logic       pwm_en;
    logic [1:0] state;
    logic       fault_latched;

    int tests = 0;
    int fails = 0;

    pwm_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_duty      (cfg_duty),
        .cfg_deadtime  (cfg_deadtime),
        .start         (start),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .period_end    (period_end),
        .duty_cmd      (duty_cmd),
        .deadtime_cmd  (deadtime_cmd),
        .pwm_en        (pwm_en),
        .state         (state),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int d, input int dt, input int en,
                            input int st, input int rdy, input int fl);
        chk({tag, ".duty"}, 32'(duty_cmd), 32'(d));
        chk({tag, ".dt"}, 32'(deadtime_cmd), 32'(dt));
        chk({tag, ".en"}, 32'(pwm_en), 32'(en));
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ready"}, 32'(cfg_ready), 32'(rdy));
        chk({tag, ".flt"}, 32'(fault_latched), 32'(fl));
    endtask

    task automatic send_cfg(input int d, input int dt);
        cfg_valid    = 1'b1;
        cfg_duty     = 10'(d);
        cfg_deadtime = 6'(dt);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_pe();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; cfg_duty = '0; cfg_deadtime = '0;
        start = 1'b0; fault = 1'b0; fault_clr = 1'b0; period_end = 1'b0;
        tick(); tick();
        chk_outs("reset", 0, 8, 0, 0, 1, 0);
        rst = 1'b1;
        tick();

        // config in IDLE commits the cycle after acceptance
        send_cfg(10, 20);
        chk("idle_accept.ready", 32'(cfg_ready), 0);
        tick();
        chk_outs("idle_commit", 0, 20, 0, 0, 1, 0);

        start = 1'b1;
        tick();
`ifdef PWM_SOFTSTART_EN
        chk_outs("ramp_entry", 0, 20, 1, 1, 1, 0);
        pulse_pe();
        chk("ramp1.duty", 32'(duty_cmd), 4);
        chk("ramp1.state", 32'(state), 1);
        pulse_pe();
        chk("ramp2.duty", 32'(duty_cmd), 8);
        chk("ramp2.state", 32'(state), 1);
        pulse_pe();
        chk_outs("ramp3", 10, 20, 1, 2, 1, 0);
`else
        chk_outs("run_entry", 10, 20, 1, 2, 1, 0);
`endif

        // accept coinciding with period_end waits for the next period_end
        cfg_valid = 1'b1; cfg_duty = 10'd500; cfg_deadtime = 6'd20; period_end = 1'b1;
        tick();
        cfg_valid = 1'b0; period_end = 1'b0;
        chk("bnd_hold.duty", 32'(duty_cmd), 10);
        chk("bnd_hold.ready", 32'(cfg_ready), 0);
        tick();
        chk("bnd_wait.duty", 32'(duty_cmd), 10);
        pulse_pe();
        chk("bnd_commit.duty", 32'(duty_cmd), 500);
        chk("bnd_commit.ready", 32'(cfg_ready), 1);

        // clamping in RUN
        send_cfg(1023, 3);
        pulse_pe();
        chk_outs("clamp", 1000, 8, 1, 2, 1, 0);

        start = 1'b0;
        tick();
        chk_outs("stop", 0, 8, 0, 0, 1, 0);

        pulse_pe();
        chk_outs("idle_pe", 0, 8, 0, 0, 1, 0);

        send_cfg(300, 10);
        tick();
        chk("t300.dt", 32'(deadtime_cmd), 10);
        start = 1'b1;
        tick();
`ifdef PWM_SOFTSTART_EN
        chk_outs("t300_entry", 0, 10, 1, 1, 1, 0);
        pulse_pe();
        chk("t300_ramp.duty", 32'(duty_cmd), 4);
`else
        chk_outs("t300_entry", 300, 10, 1, 2, 1, 0);
        pulse_pe();
        chk("t300_run.duty", 32'(duty_cmd), 300);
`endif

        fault = 1'b1;
        tick();
        chk_outs("fault", 0, 10, 0, 3, 1, 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fclr_fault_hi.state", 32'(state), 3);
        chk("fclr_fault_hi.flt", 32'(fault_latched), 1);
        fault = 1'b0; fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fclr_start_hi.state", 32'(state), 3);
        start = 1'b0; fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk_outs("fclr_ok", 0, 10, 0, 0, 1, 0);

        // zero target reaches RUN at the first period_end
        send_cfg(0, 20);
        tick();
        start = 1'b1;
        tick();
`ifdef PWM_SOFTSTART_EN
        chk("t0_entry.state", 32'(state), 1);
        pulse_pe();
`endif
        chk_outs("t0_run", 0, 20, 1, 2, 1, 0);

        send_cfg(200, 30);
        pulse_pe();
        chk("run_follow.duty", 32'(duty_cmd), 200);
        chk("run_follow.dt", 32'(deadtime_cmd), 30);

        // leave a config pending, then reset asynchronously mid-cycle
        send_cfg(100, 40);
        chk("pend.ready", 32'(cfg_ready), 0);
        #2;
        rst = 1'b0;
        #1;
        chk_outs("async_reset", 0, 8, 0, 0, 1, 0);
        tick();
        rst = 1'b1;
        start = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
